program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer side of the instruction memory: receives a program as a byte stream over a valid/ready handshake.
- Assembles the bytes into INSTRUCTION_WIDTH-bit instruction words and writes them to instruction memory at consecutive addresses from 0.
- Holds the processor (control unit) in reset while loading and releases it once a complete, valid program is in memory.
- Sits at top level between the host byte link and the instruction memory's write port; control reads the same memory via its instruction address.

Parameters:
- INSTRUCTION_WIDTH, 16, instruction word width. Must be 16, i.e. two bytes, big-endian.
- ADDRESS_WIDTH, 11, instruction memory address width. Memory depth is 2**ADDRESS_WIDTH words.

Ports:
- clock_in  input  1  system clock; all state changes on the rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- start_in  input  1  single-cycle request to begin a load. Sampled only in IDLE, DONE and ERROR.
- byte_in  input  8  stream byte.
- byte_valid_in  input  1  byte_in holds a valid byte.
- byte_ready_out  output  1  loader can accept a byte. A transfer occurs when valid and ready are both 1 at a rising edge.
- imem_address_out  output  ADDRESS_WIDTH  write address.
- imem_data_out  output  INSTRUCTION_WIDTH  write data.
- imem_wr_out  output  1  write strobe, one cycle per word.
- cpu_hold_out  output  1  1 = processor must be held in reset.
- busy_out  output  1  load in progress.
- done_out  output  1  last load completed successfully (sticky).
- error_out  output  1  last load failed (sticky).

Behaviour:
- Reset (async, reset_in=0):
  - State IDLE, all counters 0.
  - byte_ready_out, imem_wr_out, busy_out, done_out, error_out = 0.
  - imem_address_out = 0, imem_data_out = 0.
  - cpu_hold_out = 1.
- Stream format:
  - Header: COUNT_HI, COUNT_LO, forming a 16-bit word count. Only the low ADDRESS_WIDTH+1 bits are significant; nonzero upper bits are an error.
  - Payload: COUNT words, each as HI byte then LO byte.
  - Trailer: CHECKSUM byte (see Optional Feature).
- States: IDLE, HDR_HI, HDR_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR.
  - IDLE/DONE/ERROR, start_in=1: go to HDR_HI.
    - On entry: cpu_hold_out=1, busy_out=1, done_out=0, error_out=0, address counter 0, checksum accumulator 0.
  - HDR_HI/HDR_LO/DATA_HI/DATA_LO/CHECK: byte_ready_out=1. Advance only on a transfer; byte_valid_in gaps of any length stall with no state change.
  - HDR_LO transfer:
    - count > 2**ADDRESS_WIDTH: go to ERROR.
    - count = 0: go to CHECK.
    - Otherwise: go to DATA_HI.
  - DATA_LO transfer: go to WRITE.
  - WRITE: byte_ready_out=0; imem_wr_out=1 for exactly this one cycle.
    - Write address = current counter; data = {HI, LO}. Write occurs one cycle after the LO transfer.
    - Next: address +1, remaining count -1.
    - Go to CHECK if this was the last word, else DATA_HI.
  - CHECK transfer: go to DONE if the checksum matches, else ERROR.
  - DONE: cpu_hold_out=0, done_out=1, busy_out=0, byte_ready_out=0.
  - ERROR: cpu_hold_out=1, error_out=1, busy_out=0, byte_ready_out=0.
- Address counter never wraps. The maximum count 2**ADDRESS_WIDTH ends with the last write at address 2**ADDRESS_WIDTH-1.
- start_in during an active load is ignored.
- Reset mid-load aborts immediately. Words already written stay in memory; cpu_hold_out=1.
- imem_address_out and imem_data_out keep their last driven values outside WRITE; only imem_wr_out qualifies them.

Optional Feature:
- LOADER_CHECKSUM_EN defined:
  - Accumulator = XOR of every header and payload byte.
  - CHECK compares the received CHECKSUM byte against the accumulator.
- Not defined:
  - No trailer byte and no accumulator logic.
  - Where the flow above goes to CHECK, go directly to DONE instead.
  - The CHECKSUM state is removed from the enum.

Decomposition:
- Package tcc_loader_pkg:
  - loader_state_t enum.
  - BYTE_WIDTH=8, COUNT_WIDTH=16.
  - Function returning the max word count for a given ADDRESS_WIDTH.
- One sub-module, loader_word_assembler: byte-pair register producing {HI, LO} plus the XOR accumulator (accumulator present only under LOADER_CHECKSUM_EN).
- FSM stays in program_loader.

Test Plan:
- Reset then idle:
  - cpu_hold_out=1, all other outputs 0.
  - byte_valid_in=1 with no start_in → no transfers.
- start_in, stream 00 03 08 00 10 01 70 00 + checksum 6A (with EN):
  - Writes 0x0800@0, 0x1001@1, 0x7000@2.
  - Each imem_wr_out one cycle after its LO byte.
  - Then done_out=1, cpu_hold_out=0.
- Same stream, checksum 6B → error_out=1, cpu_hold_out=1, done_out=0.
- Header 08 01 (count 2049) → ERROR right after the HDR_LO transfer, zero writes.
- Header 00 00, checksum 00 → DONE with no writes.
- Random byte_valid_in gaps, plus reset_in=0 pulse after the second write:
  - Gaps cause no lost or duplicated bytes.
  - Reset returns all outputs to reset values immediately.
  - A subsequent start_in reloads from address 0.

Source files
------------

// File: rtl/tcc_loader_pkg.sv
// Shared types and constants for the program loader.
// LOADER_CHECKSUM_EN adds the CHECK state used for the trailing checksum byte.
package tcc_loader_pkg;

    localparam int unsigned BYTE_WIDTH  = 8;
    localparam int unsigned COUNT_WIDTH = 16;

    typedef enum logic [3:0] {
        StIdle,
        StHdrHi,
        StHdrLo,
        StDataHi,
        StDataLo,
        StWrite,
`ifdef LOADER_CHECKSUM_EN
        StCheck,
`endif
        StDone,
        StError
    } loader_state_t;

    // Largest word count that fits a memory of 2**aw words.
    function automatic logic [COUNT_WIDTH-1:0] max_word_count(input int unsigned aw);
        return COUNT_WIDTH'(1) << aw;
    endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Holds the high byte of a pair and presents {HI, LO} with the incoming LO byte.
// Under LOADER_CHECKSUM_EN it also keeps the running XOR of accepted bytes.
module loader_word_assembler
    import tcc_loader_pkg::*;
(
    input  logic                    clock_in,
    input  logic                    reset_in,
    input  logic [BYTE_WIDTH-1:0]   byte_in,
    input  logic                    hi_load,
`ifdef LOADER_CHECKSUM_EN
    input  logic                    acc_clear,
    input  logic                    acc_load,
    output logic [BYTE_WIDTH-1:0]   checksum,
`endif
    output logic [2*BYTE_WIDTH-1:0] word
);

    logic [BYTE_WIDTH-1:0] hi_q;

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            hi_q <= '0;
        end else if (hi_load) begin
            hi_q <= byte_in;
        end
    end

    // LO is taken straight from the stream so the word is ready on the LO transfer edge.
    assign word = {hi_q, byte_in};

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] acc_q;

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            acc_q <= '0;
        end else if (acc_clear) begin
            acc_q <= '0;
        end else if (acc_load) begin
            acc_q <= acc_q ^ byte_in;
        end
    end

    assign checksum = acc_q;
`endif

endmodule

// File: rtl/program_loader.sv
// Loads a byte-streamed program into instruction memory and holds the CPU in reset meanwhile.
// Define LOADER_CHECKSUM_EN to require and verify a trailing XOR checksum byte.
module program_loader
    import tcc_loader_pkg::*;
#(
    parameter int unsigned INSTRUCTION_WIDTH = 16,
    parameter int unsigned ADDRESS_WIDTH     = 11
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         start_in,
    input  logic [BYTE_WIDTH-1:0]        byte_in,
    input  logic                         byte_valid_in,
    output logic                         byte_ready_out,
    output logic [ADDRESS_WIDTH-1:0]     imem_address_out,
    output logic [INSTRUCTION_WIDTH-1:0] imem_data_out,
    output logic                         imem_wr_out,
    output logic                         cpu_hold_out,
    output logic                         busy_out,
    output logic                         done_out,
    output logic                         error_out
);

    localparam int unsigned CntW = ADDRESS_WIDTH + 1;
    localparam logic [COUNT_WIDTH-1:0] MaxCount = max_word_count(ADDRESS_WIDTH);
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t TailState = StCheck;
`else
    localparam loader_state_t TailState = StDone;
`endif

    loader_state_t                state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]     addr_q;
    logic [CntW-1:0]              remaining_q;
    logic                         byte_ready_q, imem_wr_q, cpu_hold_q, busy_q, done_q, error_q;
    logic [ADDRESS_WIDTH-1:0]     imem_address_q;
    logic [INSTRUCTION_WIDTH-1:0] imem_data_q;
    logic [2*BYTE_WIDTH-1:0]      word;
    logic                         transfer, start_load, hi_load, last_word;

    assign transfer   = byte_valid_in && byte_ready_q;
    assign start_load = start_in && (state_q inside {StIdle, StDone, StError});
    assign hi_load    = transfer && (state_q inside {StHdrHi, StDataHi});
    assign last_word  = (remaining_q == CntW'(1));

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] checksum;
    logic                  acc_load;

    assign acc_load = transfer && (state_q inside {StHdrHi, StHdrLo, StDataHi, StDataLo});
`endif

    loader_word_assembler u_assembler (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .byte_in  (byte_in),
        .hi_load  (hi_load),
`ifdef LOADER_CHECKSUM_EN
        .acc_clear(start_load),
        .acc_load (acc_load),
        .checksum (checksum),
`endif
        .word     (word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone, StError: if (start_in) state_d = StHdrHi;
            StHdrHi:  if (transfer) state_d = StHdrLo;
            StHdrLo: begin
                if (transfer) begin
                    if (word > MaxCount)   state_d = StError;
                    else if (word == '0)   state_d = TailState;
                    else                   state_d = StDataHi;
                end
            end
            StDataHi: if (transfer) state_d = StDataLo;
            StDataLo: if (transfer) state_d = StWrite;
            StWrite:  state_d = last_word ? TailState : StDataHi;
`ifdef LOADER_CHECKSUM_EN
            StCheck:  if (transfer) state_d = (checksum == byte_in) ? StDone : StError;
`endif
            default:  state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            remaining_q    <= '0;
            byte_ready_q   <= 1'b0;
            imem_wr_q      <= 1'b0;
            cpu_hold_q     <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            imem_address_q <= '0;
            imem_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            byte_ready_q <= state_d inside {StHdrHi, StHdrLo, StDataHi, StDataLo
`ifdef LOADER_CHECKSUM_EN
                                            , StCheck
`endif
                                            };
            imem_wr_q    <= (state_d == StWrite);
            cpu_hold_q   <= (state_d != StDone);
            busy_q       <= !(state_d inside {StIdle, StDone, StError});
            done_q       <= (state_d == StDone);
            error_q      <= (state_d == StError);

            if (start_load) begin
                addr_q      <= '0;
                remaining_q <= '0;
            end
            if (state_q == StHdrLo && transfer) begin
                remaining_q <= word[CntW-1:0];
            end
            if (state_q == StDataLo && transfer) begin
                imem_address_q <= addr_q;
                imem_data_q    <= word;
            end
            // Saturate on the final word so the address never wraps past the top.
            if (state_q == StWrite) begin
                remaining_q <= remaining_q - CntW'(1);
                if (!last_word) addr_q <= addr_q + ADDRESS_WIDTH'(1);
            end
        end
    end

    assign byte_ready_out   = byte_ready_q;
    assign imem_wr_out      = imem_wr_q;
    assign imem_address_out = imem_address_q;
    assign imem_data_out    = imem_data_q;
    assign cpu_hold_out     = cpu_hold_q;
    assign busy_out         = busy_q;
    assign done_out         = done_q;
    assign error_out        = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; follows LOADER_CHECKSUM_EN to send or omit the trailer.
module tb_program_loader;

    logic        clock_in = 1'b0;
    logic        reset_in;
    logic        start_in;
    logic [7:0]  byte_in;
    logic        byte_valid_in;
    logic        byte_ready_out;
    logic [10:0] imem_address_out;
    logic [15:0] imem_data_out;
    logic        imem_wr_out;
    logic        cpu_hold_out;
    logic        busy_out;
    logic        done_out;
    logic        error_out;

    int tests = 0;
    int fails = 0;

    int          wr_count = 0;
    int          lat_err  = 0;
    int          cycle    = 0;
    int          last_xfer_cycle = -10;
    logic [10:0] wr_addr [4096];
    logic [15:0] wr_data [4096];

    program_loader #(
        .INSTRUCTION_WIDTH(16),
        .ADDRESS_WIDTH    (11)
    ) dut (
        .clock_in        (clock_in),
        .reset_in        (reset_in),
        .start_in        (start_in),
        .byte_in         (byte_in),
        .byte_valid_in   (byte_valid_in),
        .byte_ready_out  (byte_ready_out),
        .imem_address_out(imem_address_out),
        .imem_data_out   (imem_data_out),
        .imem_wr_out     (imem_wr_out),
        .cpu_hold_out    (cpu_hold_out),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .error_out       (error_out)
    );

    always #5 clock_in = ~clock_in;

    // Memory-side monitor: logs writes and checks each follows a transfer by one cycle.
    always @(posedge clock_in) begin
        if (imem_wr_out === 1'b1) begin
            if (wr_count < 4096) begin
                wr_addr[wr_count] = imem_address_out;
                wr_data[wr_count] = imem_data_out;
            end
            wr_count = wr_count + 1;
            if (cycle != last_xfer_cycle + 1) lat_err = lat_err + 1;
        end
        if (byte_valid_in === 1'b1 && byte_ready_out === 1'b1) last_xfer_cycle = cycle;
        cycle = cycle + 1;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        byte_valid_in = 1'b0;
        repeat (gap) @(negedge clock_in);
        byte_in       = b;
        byte_valid_in = 1'b1;
        n = 0;
        while (byte_ready_out !== 1'b1 && n < 100) begin
            @(negedge clock_in);
            n++;
        end
        if (n >= 100) begin
            tests++; fails++;
            $display("FAIL send_byte_timeout byte=%02h ready=%b required ready=1", b, byte_ready_out);
        end
        @(negedge clock_in);
        byte_valid_in = 1'b0;
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        @(negedge clock_in);
        start_in = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (done_out !== 1'b1 && error_out !== 1'b1 && n < 50) begin
            @(negedge clock_in);
            n++;
        end
        tests++;
        if (n >= 50) begin
            fails++;
            $display("FAIL wait_end_timeout done=%b error=%b required one of them 1", done_out, error_out);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        // Not a shared checker: only used to keep each output line compact.
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s got %b required %b", name, act, req);
        end
    endtask

    task automatic test_reset();
        int base;
        reset_in = 1'b0; start_in = 1'b0; byte_valid_in = 1'b0; byte_in = 8'h00;
        repeat (3) @(negedge clock_in);
        tests++;
        if ({cpu_hold_out, byte_ready_out, imem_wr_out, busy_out, done_out, error_out} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_flags got hold/rdy/wr/busy/done/err=%b required 100000",
                     {cpu_hold_out, byte_ready_out, imem_wr_out, busy_out, done_out, error_out});
        end
        tests++;
        if (imem_address_out !== 11'd0 || imem_data_out !== 16'h0000) begin
            fails++;
            $display("FAIL reset_bus got addr=%0d data=%04h required 0/0000", imem_address_out, imem_data_out);
        end
        reset_in = 1'b1;
        @(negedge clock_in);
        base = wr_count;
        byte_in = 8'h55; byte_valid_in = 1'b1;
        repeat (5) @(negedge clock_in);
        check_bit("idle_no_ready", byte_ready_out, 1'b0);
        check_bit("idle_not_busy", busy_out, 1'b0);
        tests++;
        if (wr_count != base || last_xfer_cycle != -10) begin
            fails++;
            $display("FAIL idle_no_transfer got writes=%0d last_xfer=%0d required 0/-10", wr_count - base, last_xfer_cycle);
        end
        byte_valid_in = 1'b0;
    endtask

    task automatic test_load(input logic [7:0] csum, input logic expect_ok);
        int base = wr_count;
        int lat0 = lat_err;
        pulse_start();
        check_bit("load_busy", busy_out, 1'b1);
        check_bit("load_hold", cpu_hold_out, 1'b1);
        send_byte(8'h00, 0); send_byte(8'h03, 1);
        send_byte(8'h08, 0); send_byte(8'h00, 2);
        start_in = 1'b1;  // ignored mid-load
        send_byte(8'h10, 0);
        start_in = 1'b0;
        send_byte(8'h01, 0);
        send_byte(8'h70, 3); send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum, 0);
`else
        if (csum != 8'h6A) ;
`endif
        wait_end();
        tests++;
        if (wr_count - base != 3) begin
            fails++;
            $display("FAIL load_write_count got %0d required 3", wr_count - base);
        end else begin
            tests++;
            if (wr_addr[base] !== 11'd0 || wr_data[base] !== 16'h0800 ||
                wr_addr[base+1] !== 11'd1 || wr_data[base+1] !== 16'h1001 ||
                wr_addr[base+2] !== 11'd2 || wr_data[base+2] !== 16'h7000) begin
                fails++;
                $display("FAIL load_words got %04h@%0d %04h@%0d %04h@%0d required 0800@0 1001@1 7000@2",
                         wr_data[base], wr_addr[base], wr_data[base+1], wr_addr[base+1],
                         wr_data[base+2], wr_addr[base+2]);
            end
        end
        tests++;
        if (lat_err != lat0) begin
            fails++;
            $display("FAIL load_write_latency got %0d late writes required 0", lat_err - lat0);
        end
        check_bit("load_done", done_out, expect_ok);
        check_bit("load_error", error_out, !expect_ok);
        check_bit("load_hold_end", cpu_hold_out, !expect_ok);
        check_bit("load_busy_end", busy_out, 1'b0);
        check_bit("load_ready_end", byte_ready_out, 1'b0);
    endtask

    task automatic test_count_overflow();
        int base = wr_count;
        pulse_start();
        send_byte(8'h08, 0); send_byte(8'h01, 0);
        check_bit("ovf_error", error_out, 1'b1);
        check_bit("ovf_done", done_out, 1'b0);
        check_bit("ovf_hold", cpu_hold_out, 1'b1);
        check_bit("ovf_ready", byte_ready_out, 1'b0);
        repeat (3) @(negedge clock_in);
        tests++;
        if (wr_count != base) begin
            fails++;
            $display("FAIL ovf_writes got %0d required 0", wr_count - base);
        end
    endtask

    task automatic test_empty();
        int base = wr_count;
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        wait_end();
        check_bit("empty_done", done_out, 1'b1);
        check_bit("empty_hold", cpu_hold_out, 1'b0);
        tests++;
        if (wr_count != base) begin
            fails++;
            $display("FAIL empty_writes got %0d required 0", wr_count - base);
        end
    endtask

    task automatic test_max_count();
        int base = wr_count;
        int bad = 0;
        logic [7:0] cs = 8'h08;
        logic [15:0] w;
        pulse_start();
        send_byte(8'h08, 0); send_byte(8'h00, 0);
        for (int i = 0; i < 2048; i++) begin
            w = 16'(i) ^ 16'h5A3C;
            send_byte(w[15:8], 0); send_byte(w[7:0], 0);
            cs = cs ^ w[15:8] ^ w[7:0];
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(cs, 0);
`endif
        wait_end();
        check_bit("max_done", done_out, 1'b1);
        tests++;
        if (wr_count - base != 2048) begin
            fails++;
            $display("FAIL max_write_count got %0d required 2048", wr_count - base);
        end else begin
            for (int i = 0; i < 2048; i++) begin
                w = 16'(i) ^ 16'h5A3C;
                if (wr_addr[base+i] !== 11'(i) || wr_data[base+i] !== w) bad++;
            end
            tests++;
            if (bad != 0 || wr_addr[base+2047] !== 11'd2047) begin
                fails++;
                $display("FAIL max_words got %0d bad, last addr %0d required 0 bad, last addr 2047",
                         bad, wr_addr[base+2047]);
            end
        end
    endtask

    task automatic test_gaps_reset();
        int base = wr_count;
        int n = 0;
        pulse_start();
        send_byte(8'h00, $urandom_range(0, 3)); send_byte(8'h04, $urandom_range(0, 3));
        send_byte(8'hA1, $urandom_range(0, 3)); send_byte(8'hB2, $urandom_range(0, 3));
        send_byte(8'hC3, $urandom_range(0, 3)); send_byte(8'hD4, $urandom_range(0, 3));
        while (wr_count - base < 2 && n < 20) begin
            @(negedge clock_in);
            n++;
        end
        reset_in = 1'b0;
        #1;
        tests++;
        if ({cpu_hold_out, byte_ready_out, imem_wr_out, busy_out, done_out, error_out} !== 6'b100000 ||
            imem_address_out !== 11'd0 || imem_data_out !== 16'h0000) begin
            fails++;
            $display("FAIL midreset_outputs got flags=%b addr=%0d data=%04h required 100000/0/0000",
                     {cpu_hold_out, byte_ready_out, imem_wr_out, busy_out, done_out, error_out},
                     imem_address_out, imem_data_out);
        end
        tests++;
        if (wr_count - base != 2 || wr_data[base] !== 16'hA1B2 || wr_data[base+1] !== 16'hC3D4 ||
            wr_addr[base+1] !== 11'd1) begin
            fails++;
            $display("FAIL gap_words got n=%0d %04h %04h required 2 A1B2 C3D4", wr_count - base,
                     wr_data[base], wr_data[base+1]);
        end
        @(negedge clock_in);
        reset_in = 1'b1;
        @(negedge clock_in);
        base = wr_count;
        pulse_start();
        send_byte(8'h00, $urandom_range(0, 4)); send_byte(8'h02, $urandom_range(0, 4));
        send_byte(8'h12, $urandom_range(0, 4)); send_byte(8'h34, $urandom_range(0, 4));
        send_byte(8'h56, $urandom_range(0, 4)); send_byte(8'h78, $urandom_range(0, 4));
`ifdef LOADER_CHECKSUM_EN
        // 00^02^12^34^56^78 = 0A
        send_byte(8'h0A, $urandom_range(0, 4));
`endif
        wait_end();
        check_bit("reload_done", done_out, 1'b1);
        tests++;
        if (wr_count - base != 2 || wr_addr[base] !== 11'd0 || wr_data[base] !== 16'h1234 ||
            wr_addr[base+1] !== 11'd1 || wr_data[base+1] !== 16'h5678) begin
            fails++;
            $display("FAIL reload_words got n=%0d %04h@%0d %04h@%0d required 1234@0 5678@1",
                     wr_count - base, wr_data[base], wr_addr[base], wr_data[base+1], wr_addr[base+1]);
        end
    endtask

    initial begin
        test_reset();
        test_load(8'h6A, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        test_load(8'h6B, 1'b0);
`endif
        test_count_overflow();
        test_empty();
        test_max_count();
        test_gaps_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
